// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, constants and the buffered-entry payload for the
// instruction-fetch stage.
package fetch_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ADDR_W  = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [ADDR_W-1:0]  PC_STEP   = 32'd4;

    // One fetched instruction together with the byte address it came from.
    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Clears the byte-offset bits so the result is a word address.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
        return a & ~ADDR_W'(3);
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory read port.
//   master (fetch side): drives imem_req_valid, imem_addr; receives
//                        imem_req_ready, imem_rsp_valid, imem_rsp_data
//   slave  (memory side): the mirror image
interface fetch_stage_if;
    import fetch_pkg::*;

    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetch_entry_t (DEPTH a power of 2, >= 2).
//   clk, rst     : clock, synchronous active-high reset
//   flush        : empties the FIFO; wins over push and pop
//   push/push_data, pop : enqueue / dequeue
//   head_c       : current head entry (combinational read)
//   count, empty, full : registered occupancy status
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    output fetch_entry_t     head_c,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             empty_q, full_q;
    logic             do_push, do_pop;

    // Next-state: flush resets pointers, otherwise push/pop move them.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = push && !flush;
        do_pop   = pop && !flush && !empty_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= (count_d == '0);
            full_q   <= (count_d == CNT_W'(DEPTH));
        end
    end

    // The fetch credit scheme must never let a push land on a full buffer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && !flush && !pop && full_q))
                else $error("fetch_fifo overflow");
        end
    end

    assign head_c = mem_q[rd_ptr_q];
    assign count  = count_q;
    assign empty  = empty_q;
    assign full   = full_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS instruction-fetch stage.
//   CLK, RST        : clock, synchronous active-high reset
//   imem            : instruction-memory read port (fetch_stage_if.master)
//   decode_ready    : Decode accepts the presented instruction
//   inst_valid, instruction, pc_out : registered instruction to Decode
//   redirect_valid, redirect_pc     : branch/jump redirect pulse and target
// Optional: define FETCH_PERF_CNT_EN to add perf_stall_cycles,
// perf_bubble_cycles and perf_squashed counters.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned       FIFO_DEPTH = 4
) (
    input  logic               CLK,
    input  logic               RST,
    fetch_stage_if.master      imem,
    input  logic               decode_ready,
    output logic               inst_valid,
    output logic [INSTR_W-1:0] instruction,
    output logic [ADDR_W-1:0]  pc_out,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        perf_stall_cycles,
    output logic [31:0]        perf_bubble_cycles,
    output logic [31:0]        perf_squashed
`endif
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0]   outstanding_q, outstanding_d;
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
    logic               inst_valid_q, inst_valid_d;
    logic [INSTR_W-1:0] instruction_q, instruction_d;
    logic [ADDR_W-1:0]  pc_out_q, pc_out_d;

    logic               req_valid_c;
    logic               grant, drop, push, pop;
    fetch_entry_t       push_entry, fifo_head;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_empty, fifo_full;

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (CLK),
        .rst       (RST),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head_c    (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Credit check: in-flight reads plus buffered entries never exceed the FIFO.
    assign req_valid_c = !RST && !redirect_valid &&
                         ((SUM_W'(outstanding_q) + SUM_W'(fifo_count)) < SUM_W'(FIFO_DEPTH));
    assign imem.imem_req_valid = req_valid_c;
    assign imem.imem_addr      = pc_q;

    // Next-state for PC tracking, squash accounting and the Decode register.
    always_comb begin
        pc_d          = pc_q;
        rsp_pc_d      = rsp_pc_q;
        drop_cnt_d    = drop_cnt_q;
        inst_valid_d  = inst_valid_q;
        instruction_d = instruction_q;
        pc_out_d      = pc_out_q;
        grant         = req_valid_c && imem.imem_req_ready;
        drop          = imem.imem_rsp_valid && (redirect_valid || (drop_cnt_q != '0));
        push          = imem.imem_rsp_valid && !drop;
        pop           = !fifo_empty && (!inst_valid_q || decode_ready) && !redirect_valid;
        push_entry.pc    = rsp_pc_q;
        push_entry.instr = imem.imem_rsp_data;

        outstanding_d = outstanding_q + CNT_W'(grant) - CNT_W'(imem.imem_rsp_valid);

        if (redirect_valid) begin
            pc_d          = word_align(redirect_pc);
            rsp_pc_d      = word_align(redirect_pc);
            // Every read still in flight after this cycle predates the redirect.
            drop_cnt_d    = outstanding_q - CNT_W'(imem.imem_rsp_valid);
            inst_valid_d  = 1'b0;
            instruction_d = NOP_INSTR;
        end else begin
            if (grant) begin
                pc_d = pc_q + PC_STEP;
            end
            if (push) begin
                rsp_pc_d = rsp_pc_q + PC_STEP;
            end
            if (drop) begin
                drop_cnt_d = drop_cnt_q - CNT_W'(1);
            end
            if (pop) begin
                inst_valid_d  = 1'b1;
                instruction_d = fifo_head.instr;
                pc_out_d      = fifo_head.pc;
            end else if (decode_ready) begin
                inst_valid_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_q          <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            inst_valid_q  <= 1'b0;
            instruction_q <= NOP_INSTR;
            pc_out_q      <= '0;
        end else begin
            pc_q          <= pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            inst_valid_q  <= inst_valid_d;
            instruction_q <= instruction_d;
            pc_out_q      <= pc_out_d;
        end
    end

    assign inst_valid  = inst_valid_q;
    assign instruction = instruction_q;
    assign pc_out      = pc_out_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_q, stall_d;
    logic [31:0] bubble_q, bubble_d;
    logic [31:0] squash_q, squash_d;

    // Free-running wrapping event counters.
    always_comb begin
        stall_d  = stall_q  + 32'(inst_valid_q && !decode_ready);
        bubble_d = bubble_q + 32'(!inst_valid_q && !RST);
        squash_d = squash_q + 32'(drop);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_q  <= '0;
            bubble_q <= '0;
            squash_q <= '0;
        end else begin
            stall_q  <= stall_d;
            bubble_q <= bubble_d;
            squash_q <= squash_d;
        end
    end

    assign perf_stall_cycles  = stall_q;
    assign perf_bubble_cycles = bubble_q;
    assign perf_squashed      = squash_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage with a
// fixed-latency in-order instruction-memory model.
module tb_fetch_stage;
    import fetch_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam int unsigned DEPTH    = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        decode_ready;
    logic        inst_valid;
    logic [31:0] instruction;
    logic [31:0] pc_out;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_stall_cycles, perf_bubble_cycles, perf_squashed;
`endif

    fetch_stage_if imem ();

    fetch_stage #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
        .CLK            (clk),
        .RST            (rst),
        .imem           (imem),
        .decode_ready   (decode_ready),
        .inst_valid     (inst_valid),
        .instruction    (instruction),
        .pc_out         (pc_out),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_stall_cycles  (perf_stall_cycles),
        .perf_bubble_cycles (perf_bubble_cycles),
        .perf_squashed      (perf_squashed)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t pend[$];
    int    cyc       = 0;
    int    mem_lat   = 1;
    int    grant_cnt = 0;
    int    n_chk     = 0;
    int    n_pass    = 0;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Memory model: grants sampled mid-cycle, beats returned mem_lat cycles later.
    initial begin
        pend_t p;
        imem.imem_rsp_valid = 1'b0;
        imem.imem_rsp_data  = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            imem.imem_rsp_valid = 1'b0;
            imem.imem_rsp_data  = '0;
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                imem.imem_rsp_valid = 1'b1;
                imem.imem_rsp_data  = inst_of(pend[0].addr);
                void'(pend.pop_front());
            end
            @(negedge clk);
            if (rst) begin
                pend.delete();
            end else if (imem.imem_req_valid && imem.imem_req_ready) begin
                p.addr = imem.imem_addr;
                p.due  = cyc + mem_lat;
                pend.push_back(p);
                grant_cnt++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Starts at a drive point, returns mid-cycle of the first granted request.
    task automatic wait_req(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            mid();
            if (imem.imem_req_valid && imem.imem_req_ready) begin
                ok = 1'b1;
                break;
            end
            adv();
        end
        check({tag, "_req_seen"}, 32'(ok), 32'd1);
    endtask

    // Checks the next n instructions accepted by Decode; ends at a drive point.
    task automatic expect_stream(input string tag, input logic [31:0] first, input int n);
        logic [31:0] exp_pc = first;
        int          got    = 0;
        for (int i = 0; i < 4 * n + 30 && got < n; i++) begin
            mid();
            if (inst_valid && decode_ready) begin
                check({tag, "_pc"}, pc_out, exp_pc);
                check({tag, "_instr"}, instruction, inst_of(exp_pc));
                exp_pc = exp_pc + 32'd4;
                got++;
            end
            adv();
        end
        check({tag, "_count"}, 32'(got), 32'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        int g0;
        rst            = 1'b1;
        decode_ready   = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem.imem_req_ready = 1'b1;

        // Reset state
        adv(); adv(); mid();
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_instruction", instruction, 32'h0);
        check("rst_pc_out", pc_out, 32'h0);
        check("rst_req_valid", 32'(imem.imem_req_valid), 32'd0);
        check("rst_imem_addr", imem.imem_addr, RESET_PC);

        // Fill: grant in cycle 0, beat in cycle 1, visible in cycle 3
        adv(); rst = 1'b0;
        mid();
        check("c0_req_valid", 32'(imem.imem_req_valid), 32'd1);
        check("c0_addr", imem.imem_addr, 32'h0000_0100);
        adv(); mid();
        check("c1_addr", imem.imem_addr, 32'h0000_0104);
        adv(); mid();
        check("c2_inst_valid", 32'(inst_valid), 32'd0);
        adv(); mid();
        check("c3_inst_valid", 32'(inst_valid), 32'd1);
        check("c3_pc_out", pc_out, 32'h0000_0100);
        check("c3_instr", instruction, inst_of(32'h0000_0100));
        for (int k = 1; k <= 3; k++) begin
            adv(); mid();
            check("steady_pc", pc_out, 32'h0000_0100 + 32'(4 * k));
            check("steady_instr", instruction, inst_of(32'h0000_0100 + 32'(4 * k)));
        end

        // Stall for 10 cycles: output holds, credit limits grants
        adv();
        decode_ready = 1'b0;
        g0 = grant_cnt;
        for (int i = 0; i < 10; i++) begin
            mid();
            check("stall_valid", 32'(inst_valid), 32'd1);
            check("stall_pc", pc_out, 32'h0000_0110);
            check("stall_instr", instruction, inst_of(32'h0000_0110));
            adv();
        end
        check("stall_grants", 32'(grant_cnt - g0), 32'd2);
        decode_ready = 1'b1;
        expect_stream("resume", 32'h0000_0110, 8);

        // Drain, then 3 reads in flight at latency 4 and redirect to 0x2000
        imem.imem_req_ready = 1'b0;
        repeat (12) adv();
        mid();
        check("drain_valid", 32'(inst_valid), 32'd0);
        adv();
        imem.imem_req_ready = 1'b1;
        mem_lat = 4;
        adv(); adv(); adv();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_2000;
        mid();
        check("redir_req_blocked", 32'(imem.imem_req_valid), 32'd0);
        adv();
        redirect_valid = 1'b0;
        expect_stream("redir", 32'h0000_2000, 4);

        // Redirect coinciding with a beat, then a second redirect to 0x3000
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            mid();
            if (pend.size() > 0 && pend[0].due == cyc + 1) begin
                found = 1'b1;
                break;
            end
            adv();
        end
        check("beat_aligned", 32'(found), 32'd1);
        adv();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_2F00;
        mid();
        check("r1_req_blocked", 32'(imem.imem_req_valid), 32'd0);
        adv();
        redirect_pc = 32'h0000_3000;
        mid();
        check("r2_req_blocked", 32'(imem.imem_req_valid), 32'd0);
        adv();
        redirect_valid = 1'b0;
        mid();
        check("redir_nop_valid", 32'(inst_valid), 32'd0);
        check("redir_nop_instr", instruction, NOP_INSTR);
        adv();
        expect_stream("redir2", 32'h0000_3000, 4);

        // PC wrap-around
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        adv();
        redirect_valid = 1'b0;
        wait_req("wrap0");
        check("wrap_addr0", imem.imem_addr, 32'hFFFF_FFFC);
        adv();
        wait_req("wrap1");
        check("wrap_addr1", imem.imem_addr, 32'h0000_0000);
        adv();
        expect_stream("wrap", 32'hFFFF_FFFC, 3);

        // Misaligned redirect target is forced to a word address
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_1003;
        adv();
        redirect_valid = 1'b0;
        wait_req("misalign");
        check("misalign_addr", imem.imem_addr, 32'h0000_1000);
        adv();
        expect_stream("misalign", 32'h0000_1000, 2);

        // Reset with reads in flight and a valid instruction presented
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            mid();
            if (inst_valid && pend.size() >= 2) begin
                found = 1'b1;
                break;
            end
            adv();
        end
        check("pre_rst_busy", 32'(found), 32'd1);
        adv();
        rst = 1'b1;
        mid();
        check("rst2_req_valid", 32'(imem.imem_req_valid), 32'd0);
        adv(); mid();
        check("rst2_inst_valid", 32'(inst_valid), 32'd0);
        check("rst2_instruction", instruction, 32'h0);
        check("rst2_pc_out", pc_out, 32'h0);
        check("rst2_imem_addr", imem.imem_addr, RESET_PC);
        adv();
        rst = 1'b0;
        expect_stream("post_rst", RESET_PC, 3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
